// File: rtl/kamus_wb.sv
// kamus_wb: MEM/WB pipeline register and writeback stage with a two-state entry tracker.
// Optional retired-instruction counter (instret_o) is built only when KAMUS_WB_INSTRET_EN is defined.
//
// state | meaning
// EMPTY | no live entry in the MEM/WB register
// HELD  | live entry present, write pending or already done
module kamus_wb #(
    parameter int INSTRET_W = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] ex_rslt_i,
    input  logic [31:0] l1d_rd_data_i,
    input  logic [31:0] next_pc_i,
    input  logic [1:0]  wb_mux_sel_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        regfile_wr_en_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        regfile_wr_en_o,
    output logic [4:0]  regfile_wr_addr_o,
    output logic [31:0] regfile_wr_data_o,
    output logic        fwd_valid_o,
    output logic        retired_o,
    output logic        sel_err_o
`ifdef KAMUS_WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret_o
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic [31:0] ex_rslt_q, ld_data_q, next_pc_q;
    logic [1:0]  sel_q;
    logic [4:0]  rd_q;
    logic        we_q;
    logic        sel_err_q;
    logic        capture;
    logic        live;
    logic        sel_rsvd;
    logic [31:0] wb_data;

    assign capture = flush_i | ~stall_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            done_q    <= 1'b0;
            ex_rslt_q <= 32'h0;
            ld_data_q <= 32'h0;
            next_pc_q <= 32'h0;
            sel_q     <= 2'b00;
            rd_q      <= 5'd0;
            we_q      <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (capture) begin
                ex_rslt_q <= ex_rslt_i;
                ld_data_q <= l1d_rd_data_i;
                next_pc_q <= next_pc_i;
                sel_q     <= wb_mux_sel_i;
                rd_q      <= rd_addr_i;
                we_q      <= regfile_wr_en_i & ~flush_i;
            end
            if (sel_rsvd) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    // done marks a stalled entry whose write and retire pulse were already issued
    always_comb begin
        state_d = state_q;
        done_d  = done_q;
        if (flush_i) begin
            state_d = EMPTY;
            done_d  = 1'b0;
        end else if (stall_i) begin
            if (state_q == HELD) begin
                done_d = 1'b1;
            end
        end else begin
            state_d = valid_i ? HELD : EMPTY;
            done_d  = 1'b0;
        end
    end

    assign live     = (state_q == HELD) & ~done_q;
    assign sel_rsvd = (state_q == HELD) & (sel_q == 2'b11);

    always_comb begin
        wb_data = 32'h0;
        case (sel_q)
            2'b00:   wb_data = ex_rslt_q;
            2'b01:   wb_data = ld_data_q;
            2'b10:   wb_data = next_pc_q;
            default: wb_data = 32'h0;
        endcase
    end

    // rst_i masks the outputs so they read zero throughout the reset clock
    assign regfile_wr_en_o   = ~rst_i & live & we_q & (rd_q != 5'd0) & (sel_q != 2'b11);
    assign regfile_wr_addr_o = rst_i ? 5'd0 : rd_q;
    assign regfile_wr_data_o = rst_i ? 32'h0 : wb_data;
    assign fwd_valid_o       = regfile_wr_en_o;
    assign retired_o         = ~rst_i & live;
    assign sel_err_o         = ~rst_i & (sel_err_q | sel_rsvd);

`ifdef KAMUS_WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            instret_q <= '0;
        end else if (live) begin
            instret_q <= instret_q + INSTRET_W'(1);
        end
    end

    assign instret_o = rst_i ? '0 : instret_q;
`else
    localparam int unused_instret_w = INSTRET_W;
`endif

endmodule

// File: tb/tb_kamus_wb.sv
// Directed bench for kamus_wb: writeback muxing, x0 rule, stall/flush, reserved select, reset.
// With KAMUS_WB_INSTRET_EN defined it also exercises a 4-bit instret wrap.
module tb_kamus_wb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] ex_rslt_i;
    logic [31:0] l1d_rd_data_i;
    logic [31:0] next_pc_i;
    logic [1:0]  wb_mux_sel_i;
    logic [4:0]  rd_addr_i;
    logic        regfile_wr_en_i;
    logic        stall_i;
    logic        flush_i;
    logic        regfile_wr_en_o;
    logic [4:0]  regfile_wr_addr_o;
    logic [31:0] regfile_wr_data_o;
    logic        fwd_valid_o;
    logic        retired_o;
    logic        sel_err_o;
`ifdef KAMUS_WB_INSTRET_EN
    logic [3:0]  instret_o;
`endif

    int tests = 0;
    int fails = 0;
    int wr_pulses;
    int ret_pulses;

    kamus_wb #(
        .INSTRET_W(4)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .valid_i          (valid_i),
        .ex_rslt_i        (ex_rslt_i),
        .l1d_rd_data_i    (l1d_rd_data_i),
        .next_pc_i        (next_pc_i),
        .wb_mux_sel_i     (wb_mux_sel_i),
        .rd_addr_i        (rd_addr_i),
        .regfile_wr_en_i  (regfile_wr_en_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .regfile_wr_en_o  (regfile_wr_en_o),
        .regfile_wr_addr_o(regfile_wr_addr_o),
        .regfile_wr_data_o(regfile_wr_data_o),
        .fwd_valid_o      (fwd_valid_o),
        .retired_o        (retired_o),
        .sel_err_o        (sel_err_o)
`ifdef KAMUS_WB_INSTRET_EN
        ,
        .instret_o        (instret_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] rd,
                         input logic we, input logic [31:0] ex, input logic [31:0] ld,
                         input logic [31:0] pc);
        valid_i         = v;
        wb_mux_sel_i    = sel;
        rd_addr_i       = rd;
        regfile_wr_en_i = we;
        ex_rslt_i       = ex;
        l1d_rd_data_i   = ld;
        next_pc_i       = pc;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        stall_i = 1'b0;
        flush_i = 1'b0;
        rst_i   = 1'b1;
        drive(1'b1, 2'b00, 5'd9, 1'b1, 32'h1111_2222, 32'h0, 32'h0);
        #1;
        chk("rst_during_wr_en", 32'(regfile_wr_en_o), 32'd0);
        tick();
        chk("rst_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("rst_addr", 32'(regfile_wr_addr_o), 32'd0);
        chk("rst_data", regfile_wr_data_o, 32'h0);
        chk("rst_fwd", 32'(fwd_valid_o), 32'd0);
        chk("rst_retired", 32'(retired_o), 32'd0);
        chk("rst_sel_err", 32'(sel_err_o), 32'd0);
        tick();
        rst_i = 1'b0;
        idle();
        tick();
        chk("idle_retired", 32'(retired_o), 32'd0);

        // ALU path
        drive(1'b1, 2'b00, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h5555_5555, 32'h0000_0100);
        tick();
        chk("alu_wr_en", 32'(regfile_wr_en_o), 32'd1);
        chk("alu_addr", 32'(regfile_wr_addr_o), 32'd5);
        chk("alu_data", regfile_wr_data_o, 32'hDEAD_BEEF);
        chk("alu_retired", 32'(retired_o), 32'd1);
        chk("alu_fwd", 32'(fwd_valid_o), 32'd1);
        idle();
        tick();
        chk("alu_retired_once", 32'(retired_o), 32'd0);
        chk("alu_wr_en_once", 32'(regfile_wr_en_o), 32'd0);

        // x0 destination still retires but never writes
        drive(1'b1, 2'b01, 5'd0, 1'b1, 32'h0, 32'h1234_5678, 32'h0);
        tick();
        chk("x0_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("x0_retired", 32'(retired_o), 32'd1);
        chk("x0_data", regfile_wr_data_o, 32'h1234_5678);

        // load and link sources back to back
        drive(1'b1, 2'b01, 5'd9, 1'b1, 32'hAAAA_0000, 32'h0BAD_F00D, 32'h0000_0200);
        tick();
        chk("ld_data", regfile_wr_data_o, 32'h0BAD_F00D);
        chk("ld_wr_en", 32'(regfile_wr_en_o), 32'd1);
        drive(1'b1, 2'b10, 5'd1, 1'b1, 32'hAAAA_0000, 32'h0BAD_F00D, 32'h0000_0104);
        tick();
        chk("link_data", regfile_wr_data_o, 32'h0000_0104);
        chk("link_addr", 32'(regfile_wr_addr_o), 32'd1);

        // write enable low: retires, no write, address still visible
        drive(1'b1, 2'b00, 5'd4, 1'b0, 32'h7777_7777, 32'h0, 32'h0);
        tick();
        chk("nowe_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("nowe_retired", 32'(retired_o), 32'd1);
        chk("nowe_addr", 32'(regfile_wr_addr_o), 32'd4);

        // stall for three cycles after capture
        drive(1'b1, 2'b00, 5'd7, 1'b1, 32'hA5A5_A5A5, 32'h0, 32'h0);
        tick();
        wr_pulses  = int'(regfile_wr_en_o);
        ret_pulses = int'(retired_o);
        stall_i = 1'b1;
        drive(1'b1, 2'b01, 5'd12, 1'b1, 32'h0, 32'hFFFF_0000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            wr_pulses  += int'(regfile_wr_en_o);
            ret_pulses += int'(retired_o);
            chk("stall_addr_held", 32'(regfile_wr_addr_o), 32'd7);
            chk("stall_data_held", regfile_wr_data_o, 32'hA5A5_A5A5);
        end
        chk("stall_wr_pulses", 32'(wr_pulses), 32'd1);
        chk("stall_ret_pulses", 32'(ret_pulses), 32'd1);
        stall_i = 1'b0;
        idle();
        tick();
        chk("stall_release_retired", 32'(retired_o), 32'd0);

        // flush wins over stall
        drive(1'b1, 2'b00, 5'd8, 1'b1, 32'h0000_0008, 32'h0, 32'h0);
        tick();
        chk("pre_flush_wr_en", 32'(regfile_wr_en_o), 32'd1);
        stall_i = 1'b1;
        flush_i = 1'b1;
        drive(1'b1, 2'b00, 5'd10, 1'b1, 32'h0000_000A, 32'h0, 32'h0);
        tick();
        chk("flush_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("flush_retired", 32'(retired_o), 32'd0);
        chk("flush_fwd", 32'(fwd_valid_o), 32'd0);
        stall_i = 1'b0;
        flush_i = 1'b0;

        // reserved select is sticky until reset
        drive(1'b1, 2'b11, 5'd3, 1'b1, 32'hCAFE_CAFE, 32'hBEEF_BEEF, 32'h0000_0300);
        tick();
        chk("rsvd_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("rsvd_data", regfile_wr_data_o, 32'h0);
        chk("rsvd_sel_err", 32'(sel_err_o), 32'd1);
        chk("rsvd_retired", 32'(retired_o), 32'd1);
        idle();
        tick();
        chk("rsvd_sticky_idle", 32'(sel_err_o), 32'd1);
        drive(1'b1, 2'b00, 5'd2, 1'b1, 32'h0000_0022, 32'h0, 32'h0);
        tick();
        chk("rsvd_sticky_normal", 32'(sel_err_o), 32'd1);
        chk("after_rsvd_wr_en", 32'(regfile_wr_en_o), 32'd1);

        // reset during a stall drops the held entry and clears the flag
        drive(1'b1, 2'b00, 5'd6, 1'b1, 32'h0000_0066, 32'h0, 32'h0);
        tick();
        stall_i = 1'b1;
        tick();
        chk("stall_done_wr_en", 32'(regfile_wr_en_o), 32'd0);
        rst_i = 1'b1;
        flush_i = 1'b1;
        tick();
        chk("rst_stall_wr_en", 32'(regfile_wr_en_o), 32'd0);
        chk("rst_stall_sel_err", 32'(sel_err_o), 32'd0);
        rst_i   = 1'b0;
        flush_i = 1'b0;
        stall_i = 1'b0;
        idle();
        tick();
        chk("post_rst_retired", 32'(retired_o), 32'd0);
        chk("post_rst_sel_err", 32'(sel_err_o), 32'd0);
        chk("post_rst_wr_en", 32'(regfile_wr_en_o), 32'd0);

`ifdef KAMUS_WB_INSTRET_EN
        chk("instret_reset", 32'(instret_o), 32'd0);
        drive(1'b1, 2'b00, 5'd1, 1'b1, 32'h0000_0001, 32'h0, 32'h0);
        for (int i = 0; i < 17; i++) begin
            tick();
        end
        idle();
        tick();
        chk("instret_wrap", 32'(instret_o), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kamus_wb.md
KAMUS_WB -- requirements
Module: kamus_wb

Interface
REQ-001 SHALL have parameter INSTRET_W, default 64: width of the retired-instruction counter.
REQ-002 SHALL have port clk_i  input  1  single core clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_i  input  1  MEM stage holds a live instruction.
REQ-005 SHALL have port ex_rslt_i  input  32  ALU result forwarded by MEM.
REQ-006 SHALL have port l1d_rd_data_i  input  32  load data already sign/zero-extended by MEM.
REQ-007 SHALL have port next_pc_i  input  32  link value (PC+4) for JAL/JALR.
REQ-008 SHALL have port wb_mux_sel_i  input  2  writeback source: 00 ALU, 01 load, 10 link, 11 reserved.
REQ-009 SHALL have port rd_addr_i  input  5  destination register.
REQ-010 SHALL have port regfile_wr_en_i  input  1  instruction writes rd.
REQ-011 SHALL have port stall_i  input  1  hold the MEM/WB register.
REQ-012 SHALL have port flush_i  input  1  replace the incoming instruction with a bubble.
REQ-013 SHALL have port regfile_wr_en_o  output  1  register-file write strobe.
REQ-014 SHALL have port regfile_wr_addr_o  output  5  register-file write address.
REQ-015 SHALL have port regfile_wr_data_o  output  32  register-file write data.
REQ-016 SHALL have port fwd_valid_o  output  1  forwarding path to EX is valid; equals regfile_wr_en_o.
REQ-017 SHALL have port retired_o  output  1  one-cycle pulse per retired instruction.
REQ-018 SHALL have port sel_err_o  output  1  sticky flag: reserved wb_mux_sel seen.
REQ-019 SHALL have port instret_o  output  INSTRET_W  retired-instruction count; present only with the feature in REQ-036.

Function
REQ-020 SHALL register valid, data sources, sel, rd and write enable in a MEM/WB register on each clock with stall_i=0 and flush_i=0.
REQ-021 SHALL produce its outputs from the MEM/WB register only, one cycle after MEM capture, with no combinational path from any *_i data port to any output.
REQ-022 SHALL select regfile_wr_data_o from the registered sel: 00 ex_rslt, 01 l1d_rd_data, 10 next_pc, 11 32'h0.
REQ-023 SHALL assert regfile_wr_en_o only when registered valid=1, write enable=1, rd!=0 and sel!=11.
REQ-024 SHALL keep regfile_wr_addr_o equal to registered rd at all times, including when the write strobe is low.
REQ-025 SHALL load a bubble (valid=0, write enable=0) on a clock with flush_i=1, whatever the value of stall_i (flush has priority).
REQ-026 SHALL hold every MEM/WB field on a clock with stall_i=1 and flush_i=0, and SHALL deassert regfile_wr_en_o and retired_o while the stalled entry has already been written, so each instruction writes exactly once.
REQ-027 SHALL pulse retired_o for exactly one cycle when a valid entry leaves the register; a bubble SHALL NOT pulse it; rd=x0 and write enable=0 SHALL still pulse it.
REQ-028 SHALL set sel_err_o on the first cycle a valid entry with sel=11 is in the register, and SHALL keep it set until reset.
REQ-029 SHALL keep all per-instruction state in a two-state machine: EMPTY (no live entry) and HELD (live entry, write pending or done).
REQ-030 SHALL make these state transitions: EMPTY->HELD on valid capture; HELD->HELD on a new capture; HELD->EMPTY on a bubble capture or flush; any state->EMPTY on reset.

Reset
REQ-031 SHALL, on a clock with rst_i=1, clear the MEM/WB register to a bubble and set state EMPTY.
REQ-032 SHALL, during that reset clock, drive regfile_wr_en_o=0, regfile_wr_addr_o=0, regfile_wr_data_o=0, fwd_valid_o=0, retired_o=0, sel_err_o=0 and instret_o=0.
REQ-033 SHALL give rst_i priority over flush_i and stall_i.
REQ-034 SHALL, when reset is asserted mid-stall, drop the held entry without performing its write.
REQ-035 SHALL NOT sample any input other than rst_i on a reset clock.

Configuration
REQ-036 SHALL compile instret_o and its counter in only when macro KAMUS_WB_INSTRET_EN is defined.
REQ-037 SHALL, with KAMUS_WB_INSTRET_EN defined, increment the counter by 1 on each retired_o pulse and wrap modulo 2^INSTRET_W with no flag.
REQ-038 SHALL, without KAMUS_WB_INSTRET_EN, omit the instret_o port and leave every other behaviour unchanged.

Verification
REQ-039 SHALL verify the ALU path: valid, sel=00, rd=5, ex_rslt=32'hDEADBEEF -> next cycle wr_en=1, addr=5, data=DEADBEEF, retired_o=1 for one cycle.
REQ-040 SHALL verify the x0 rule: valid, sel=01, rd=0, load data=32'h12345678 -> wr_en=0, retired_o=1.
REQ-041 SHALL verify stall: capture with rd=7, then stall_i=1 for 3 cycles -> exactly one wr_en pulse and one retired_o pulse, with outputs held throughout.
REQ-042 SHALL verify flush priority: stall_i=1 and flush_i=1 together -> the next cycle is a bubble, wr_en=0, retired_o=0.
REQ-043 SHALL verify the reserved source: sel=11, rd=3 -> wr_en=0, data=0, sel_err_o=1 and staying at 1 until rst_i.
REQ-044 SHALL verify the counter wrap: with KAMUS_WB_INSTRET_EN and INSTRET_W=4, 17 retirements -> instret_o=1.
